// File: rtl/ahb_lite_master.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ahb_lite_master : valid/ready command to single AHB-Lite transfers
// Rev 1.0
// ---------------------------------------------------------------------------
module ahb_lite_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [2:0]            cmd_size,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] haddr,
  output logic [2:0]            hburst,
  output logic [2:0]            hsize,
  output logic [1:0]            htrans,
  output logic [DATA_WIDTH-1:0] hwdata,
  output logic                  hwrite,
  input  logic [DATA_WIDTH-1:0] hrdata,
  input  logic                  hready,
  input  logic                  hresp
);

  localparam int MAX_SIZE = $clog2(DATA_WIDTH / 8);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ADDR    = 2'd1;
  localparam logic [1:0] S_DATA    = 2'd2;
  localparam logic [1:0] S_ILLEGAL = 2'd3;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  logic [1:0]            state;
  logic [1:0]            state_next;
  logic [DATA_WIDTH-1:0] wdata_lat;
  logic [ADDR_WIDTH-1:0] align_mask;
  logic                  cmd_illegal;
  logic                  load_addr;
  logic                  load_wdata;
  logic                  finish_xfer;
  logic                  finish_illegal;

  // Only SINGLE bursts are ever issued.
  assign hburst = 3'b000;

  // Low address bits that must be zero for a naturally aligned transfer.
  assign align_mask  = ~({ADDR_WIDTH{1'b1}} << cmd_size);
  assign cmd_illegal = (cmd_size > 3'(MAX_SIZE)) || ((cmd_addr & align_mask) != '0);

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (cmd_valid) state_next = cmd_illegal ? S_ILLEGAL : S_ADDR;
      S_ADDR:  if (hready)    state_next = S_DATA;
      S_DATA:  if (hready)    state_next = S_IDLE;
      default:                state_next = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready      = 1'b0;
    load_addr      = 1'b0;
    load_wdata     = 1'b0;
    finish_xfer    = 1'b0;
    finish_illegal = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        load_addr = cmd_valid & ~cmd_illegal;
      end
      S_ADDR:  load_wdata     = hready;
      S_DATA:  finish_xfer    = hready;
      default: finish_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      htrans    <= HTRANS_IDLE;
      haddr     <= '0;
      hsize     <= 3'd0;
      hwrite    <= 1'b0;
      hwdata    <= '0;
      wdata_lat <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= finish_xfer | finish_illegal;
      if (load_addr) begin
        htrans    <= HTRANS_NONSEQ;
        haddr     <= cmd_addr;
        hsize     <= cmd_size;
        hwrite    <= cmd_write;
        wdata_lat <= cmd_wdata;
      end
      // Write data enters the bus as the address phase completes; reads leave hwdata untouched.
      if (load_wdata) begin
        htrans <= HTRANS_IDLE;
        if (hwrite) hwdata <= wdata_lat;
      end
      if (finish_xfer) begin
        rsp_err   <= hresp;
        rsp_rdata <= (!hwrite && !hresp) ? hrdata : '0;
      end
      if (finish_illegal) begin
        rsp_err   <= 1'b1;
        rsp_rdata <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ahb_lite_master.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_ahb_lite_master : directed + randomized transfers against a reference model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_ahb_lite_master;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          hclk = 1'b0;
  logic          hreset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [2:0]    cmd_size = 3'd0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] haddr;
  logic [2:0]    hburst;
  logic [2:0]    hsize;
  logic [1:0]    htrans;
  logic [DW-1:0] hwdata;
  logic          hwrite;
  logic [DW-1:0] hrdata = '0;
  logic          hready = 1'b1;
  logic          hresp = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  // Reference state: last bus write data and last response contents.
  logic [DW-1:0] last_hwdata = '0;
  logic          last_err = 1'b0;
  logic [DW-1:0] last_rdata = '0;

  ahb_lite_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .hclk(hclk), .hreset(hreset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .haddr(haddr), .hburst(hburst), .hsize(hsize), .htrans(htrans),
    .hwdata(hwdata), .hwrite(hwrite), .hrdata(hrdata), .hready(hready), .hresp(hresp)
  );

  always #5 hclk = ~hclk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_legal(input logic [2:0] size, input logic [AW-1:0] addr);
    longint bytes;
    if (int'(size) > $clog2(DW / 8)) return 1'b0;
    bytes = longint'(1) << size;
    return (longint'(addr) % bytes) == 0;
  endfunction

  // Entered and left #1 after a rising edge with the DUT idle.
  task automatic do_xfer(input bit wr, input logic [AW-1:0] addr, input logic [2:0] size,
                         input logic [DW-1:0] wd, input int aw, input int dw,
                         input bit err, input logic [DW-1:0] rd);
    bit legal;
    legal = is_legal(size, addr);
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_size = size; cmd_wdata = wd;
    hready = 1'b1; hresp = 1'b0;
    @(posedge hclk); #1;
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom); cmd_addr = $urandom; cmd_size = 3'($urandom); cmd_wdata = $urandom;
    check("rsp_valid_pulse_end", rsp_valid, 0);
    check("rsp_err_hold", rsp_err, last_err);
    check("rsp_rdata_hold", rsp_rdata, last_rdata);
    check("cmd_ready_busy", cmd_ready, 0);
    if (!legal) begin
      check("htrans_illegal", htrans, 2'b00);
      @(posedge hclk); #1;
      check("ill_rsp_valid", rsp_valid, 1);
      check("ill_rsp_err", rsp_err, 1);
      check("ill_rsp_rdata", rsp_rdata, 0);
      check("ill_htrans", htrans, 2'b00);
      last_err = 1'b1; last_rdata = '0;
      return;
    end
    check("addr_htrans", htrans, 2'b10);
    check("addr_haddr", haddr, addr);
    check("addr_hsize", hsize, size);
    check("addr_hwrite", hwrite, wr);
    check("addr_hburst", hburst, 3'b000);
    for (int i = 0; i < aw; i++) begin
      hready = 1'b0;
      @(posedge hclk); #1;
      check("addr_hold_htrans", htrans, 2'b10);
      check("addr_hold_haddr", haddr, addr);
    end
    hready = 1'b1;
    @(posedge hclk); #1;
    if (wr) last_hwdata = wd;
    check("data_htrans", htrans, 2'b00);
    check("data_hwdata", hwdata, last_hwdata);
    check("data_hburst", hburst, 3'b000);
    for (int i = 0; i < dw; i++) begin
      hready = 1'b0;
      hresp  = (err && i == dw - 1) ? 1'b1 : 1'($urandom_range(0, 1));
      hrdata = $urandom;
      @(posedge hclk); #1;
      check("wait_rsp_valid", rsp_valid, 0);
      check("wait_htrans", htrans, 2'b00);
      check("wait_hwdata", hwdata, last_hwdata);
    end
    hready = 1'b1; hresp = err; hrdata = rd;
    @(posedge hclk); #1;
    last_err   = err;
    last_rdata = (!wr && !err) ? rd : '0;
    check("rsp_valid", rsp_valid, 1);
    check("rsp_err", rsp_err, last_err);
    check("rsp_rdata", rsp_rdata, last_rdata);
    check("rsp_cmd_ready", cmd_ready, 1);
    check("rsp_htrans", htrans, 2'b00);
    hresp = 1'b0; hrdata = $urandom;
  endtask

  initial begin
    repeat (2) @(posedge hclk);
    #1;
    check("rst_htrans", htrans, 2'b00);
    check("rst_haddr", haddr, 0);
    check("rst_hsize", hsize, 0);
    check("rst_hburst", hburst, 0);
    check("rst_hwrite", hwrite, 0);
    check("rst_hwdata", hwdata, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", rsp_err, 0);
    @(negedge hclk) hreset = 1'b0;
    @(posedge hclk); #1;

    // Directed cases; each call starts in the previous response cycle (back-to-back).
    do_xfer(1'b1, 32'h0000_0010, 3'd2, 32'hDEAD_BEEF, 0, 0, 1'b0, 32'h0);
    do_xfer(1'b0, 32'h0000_0024, 3'd2, 32'h0,         0, 3, 1'b0, 32'h1234_5678);
    do_xfer(1'b0, 32'h0000_0040, 3'd2, 32'h0,         0, 1, 1'b1, 32'hFFFF_FFFF);
    do_xfer(1'b1, 32'h0000_0002, 3'd2, 32'h5555_AAAA, 0, 0, 1'b0, 32'h0);
    do_xfer(1'b0, 32'h0000_0000, 3'd3, 32'h0,         0, 0, 1'b0, 32'h0);
    do_xfer(1'b1, 32'h0000_0102, 3'd1, 32'hCAFE_F00D, 2, 1, 1'b0, 32'h0);
    do_xfer(1'b0, 32'h0000_0103, 3'd0, 32'h0,         1, 2, 1'b0, 32'h0BAD_CAFE);

    for (int n = 0; n < 60; n++) begin
      logic [2:0]    sz;
      logic [AW-1:0] ad;
      sz = 3'($urandom_range(0, 3));
      ad = $urandom;
      if ($urandom_range(0, 3) != 0) ad = (ad >> sz) << sz;
      if ($urandom_range(0, 2) == 0) begin
        @(posedge hclk); #1;
        check("idle_rsp_valid", rsp_valid, 0);
        check("idle_htrans", htrans, 2'b00);
      end
      do_xfer(1'($urandom), ad, sz, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
              ($urandom_range(0, 3) == 0), $urandom);
    end

    // Reset in the middle of a stalled data phase.
    hready = 1'b1; cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h80; cmd_size = 3'd2;
    @(posedge hclk); #1;
    cmd_valid = 1'b0;
    @(posedge hclk); #1;
    hready = 1'b0;
    @(posedge hclk); #1;
    check("mid_htrans_data", htrans, 2'b00);
    #2 hreset = 1'b1;
    #1;
    check("arst_htrans", htrans, 2'b00);
    check("arst_haddr", haddr, 0);
    check("arst_hsize", hsize, 0);
    check("arst_hwrite", hwrite, 0);
    check("arst_hwdata", hwdata, 0);
    check("arst_rsp_valid", rsp_valid, 0);
    check("arst_rsp_err", rsp_err, 0);
    check("arst_rsp_rdata", rsp_rdata, 0);
    last_hwdata = '0; last_err = 1'b0; last_rdata = '0;
    hready = 1'b1; hresp = 1'b1; hrdata = 32'h7777_7777;
    @(negedge hclk) hreset = 1'b0;
    @(posedge hclk); #1;
    check("post_rst_cmd_ready", cmd_ready, 1);
    check("post_rst_rsp_valid", rsp_valid, 0);
    check("post_rst_htrans", htrans, 2'b00);
    @(posedge hclk); #1;
    check("post_rst_rsp_valid2", rsp_valid, 0);
    hresp = 1'b0;
    do_xfer(1'b0, 32'h0000_0044, 3'd2, 32'h0, 0, 0, 1'b0, 32'hA5A5_0F0F);
    do_xfer(1'b1, 32'h0000_0048, 3'd2, 32'h0123_4567, 0, 0, 1'b0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ahb_lite_master.md
Name: ahb_lite_master

Overview:
AHB-Lite initiator that turns a simple valid/ready command interface into single AHB transfers (hburst SINGLE, htrans NONSEQ/IDLE). It drives the master-side address, control and write-data signals that feed the interconnect and slave decoders, and returns read data and error status as a one-cycle response pulse. It supports one outstanding transfer; address/data phase overlap between consecutive commands is not supported.

Parameters:
ADDR_WIDTH, 32, width of haddr and cmd_addr
DATA_WIDTH, 32, width of hwdata/hrdata/cmd_wdata/rsp_rdata; legal values 32 or 64

Ports:
hclk  input  1  bus clock; all state changes on its rising edge
hreset  input  1  asynchronous, active-high reset
cmd_valid  input  1  command request
cmd_ready  output  1  command accepted when cmd_valid & cmd_ready at a clock edge
cmd_write  input  1  1 = write, 0 = read
cmd_addr  input  ADDR_WIDTH  byte address
cmd_size  input  3  AHB hsize encoding (0 = byte, 1 = half, 2 = word, 3 = dword)
cmd_wdata  input  DATA_WIDTH  write data
rsp_valid  output  1  one-cycle response pulse
rsp_rdata  output  DATA_WIDTH  read data (0 for writes and errors)
rsp_err  output  1  transfer error or illegal command
haddr  output  ADDR_WIDTH  AHB address
hburst  output  3  always 3'b000 (SINGLE)
hsize  output  3  AHB transfer size
htrans  output  2  2'b00 IDLE or 2'b10 NONSEQ only
hwdata  output  DATA_WIDTH  AHB write data (data phase)
hwrite  output  1  AHB write control
hrdata  input  DATA_WIDTH  AHB read data
hready  input  1  AHB transfer-done / phase-advance
hresp  input  1  AHB response, 1 = ERROR

Behaviour:
- Reset (async assert, sync release): state IDLE; htrans=00, haddr=0, hsize=0, hburst=000, hwrite=0, hwdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0. cmd_ready=1 as soon as reset is deasserted.
- All AHB outputs and rsp_* are registered. cmd_ready is combinational: cmd_ready = (state==IDLE).
- States: IDLE, ADDR, DATA, ILLEGAL.
- IDLE: htrans=IDLE. On accept, the command is illegal if cmd_size > log2(DATA_WIDTH/8) or cmd_addr is not aligned to 2^cmd_size. An illegal command goes to ILLEGAL, and the bus stays IDLE. A legal command goes to ADDR, registering htrans=10, haddr, hsize, hwrite and hburst=000.
- ILLEGAL: lasts one cycle. rsp_valid=1, rsp_err=1, rsp_rdata=0 are registered on exit, then back to IDLE. No bus activity.
- ADDR: outputs hold while hready=0. At an edge with hready=1, go to DATA: htrans<=IDLE, hwdata<=latched wdata for writes (hold previous value for reads).
- DATA: wait while hready=0; hwdata holds. At an edge with hready=1, go to IDLE with rsp_valid<=1, rsp_err<=hresp, rsp_rdata<=(read & !hresp) ? hrdata : 0.
- hresp=1 with hready=0 (first error cycle) is ignored; only the value sampled with hready=1 counts. No cancellation is needed because htrans is already IDLE.
- rsp_valid is high for exactly one cycle; there is no backpressure. rsp_rdata and rsp_err hold until the next response.
- Since cmd_ready is high while rsp_valid is high, a new command can be accepted in the response cycle. Minimum command-to-command spacing is 3 cycles with zero wait states.
- Latency with zero wait states: accept at edge N; NONSEQ on bus in cycle N..N+1; data phase N+1..N+2; rsp_valid high in cycle after edge N+2.
- Reset mid-transfer: bus returns to IDLE immediately, no response is issued, and the latched command is discarded.
- cmd_* inputs are sampled only at accept; later changes are ignored.

Test Plan:
- Zero-wait write: addr 0x0000_0010, size 2, wdata 0xDEAD_BEEF, hready=1 -> htrans=10/haddr=0x10/hwrite=1 for 1 cycle, then hwdata=0xDEADBEEF; rsp_valid pulse with rsp_err=0, rsp_rdata=0.
- Read with 3 wait states: addr 0x24, size 2, slave holds hready=0 for 3 data-phase cycles then hrdata=0x1234_5678 -> rsp_valid once after the 4th data cycle, rsp_rdata=0x12345678, htrans IDLE throughout data phase.
- Two-cycle error: read addr 0x40, slave gives hresp=1/hready=0 then hresp=1/hready=1 -> rsp_err=1, rsp_rdata=0, single rsp_valid pulse.
- Illegal commands: size 2 at addr 0x2, then size 3 with DATA_WIDTH=32 -> each gives rsp_err=1 one cycle after accept, htrans stays 00.
- Back-to-back: second command held valid during the first's response cycle -> accepted that cycle, NONSEQ on the next cycle, hburst=000 always.
- Reset asserted during DATA with hready=0 -> all outputs go to reset values asynchronously, no rsp_valid, cmd_ready=1 after release.
